// File: rtl/fp_pkg.sv
// Shared types and constants for the FP32 multiplier sharing logic.
package fp_pkg;

   // Latency of the attached fp32_mul, used as the default for the arbiter.
   localparam int FP32_MUL_LATENCY = 7;

   // Tag that travels alongside an operation while the multiplier works on it.
   typedef struct packed {
      logic       valid;
      logic [2:0] id;
   } mul_tag_t;

   // Index of the set bit in a one-hot vector (0 when no bit is set).
   function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
module rr_arbiter
   import fp_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] req,
   input  logic         hold,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;
   logic [W-1:0] idx;
   logic         found;

   // Scan ptr+1, ptr+2, ... so the last winner has lowest priority.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      if (!hold) begin
         for (int k = 1; k <= N; k++) begin
            idx = W'((int'(ptr_q) + k) % N);
            if (req[idx] && !found) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

   // Pointer follows the winner only when the grant is actually taken.
   always_comb begin
      ptr_d = ptr_q;
      if (advance) ptr_d = W'(onehot_idx(8'(grant)));
   end

   // Pointer resets to the last index so requester 0 wins first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= W'(N - 1);
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/fp32_mul_arbiter.sv
// Shares one pipelined fp32_mul between NUM_REQ requesters and routes
// each product back to the requester that issued it.
module fp32_mul_arbiter
   import fp_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = FP32_MUL_LATENCY
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     hold_in,
   input  logic [NUM_REQ-1:0]       req_valid_in,
   input  logic [NUM_REQ-1:0][31:0] req_a_in,
   input  logic [NUM_REQ-1:0][31:0] req_b_in,
   output logic [NUM_REQ-1:0]       req_ready_out,
   output logic                     mul_valid_out,
   output logic [31:0]              mul_a_out,
   output logic [31:0]              mul_b_out,
   input  logic                     mul_valid_in,
   input  logic [31:0]              mul_c_in,
   output logic [NUM_REQ-1:0]       resp_valid_out,
   output logic [31:0]              resp_c_out,
   output logic                     busy_out,
   output logic                     err_out
);

   // The multiplier captures valid_in one edge after issue and then needs
   // MUL_LATENCY further edges, so the tag pipe is one stage longer.
   localparam int DEPTH = MUL_LATENCY + 1;

   logic [NUM_REQ-1:0] grant;
   logic               xfer;
   logic [31:0]        sel_a;
   logic [31:0]        sel_b;
   logic [2:0]         sel_id;

   logic               mul_valid_q;
   logic [31:0]        mul_a_q;
   logic [31:0]        mul_b_q;
   logic [2:0]         issue_id_q;

   mul_tag_t           tag_d;
   mul_tag_t           tag_q [DEPTH];
   mul_tag_t           t_out;
   logic               tag_busy;

   logic [NUM_REQ-1:0] resp_valid_q;
   logic [31:0]        resp_c_q;
   logic               err_q;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk_i   (clk_in),
      .rst_ni  (rst_in),
      .req     (req_valid_in),
      .hold    (hold_in),
      .advance (xfer),
      .grant   (grant)
   );

   // No grant can be offered while reset is asserted.
   assign req_ready_out = rst_in ? grant : '0;
   assign xfer          = |req_ready_out;

   // Select the operands and ID of the granted requester.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_id = onehot_idx(8'(req_ready_out));
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready_out[i]) begin
            sel_a = req_a_in[i];
            sel_b = req_b_in[i];
         end
      end
   end

   // Issue register: strobe every cycle, operands only change on a transfer.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mul_valid_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         issue_id_q  <= '0;
      end else begin
         mul_valid_q <= xfer;
         if (xfer) begin
            mul_a_q    <= sel_a;
            mul_b_q    <= sel_b;
            issue_id_q <= sel_id;
         end
      end
   end

   // Tag entering the pipe mirrors what the issue register sends out.
   always_comb begin
      tag_d       = '0;
      tag_d.valid = mul_valid_q;
      tag_d.id    = issue_id_q;
   end

   // Tag pipe shadows the multiplier; cleared on reset to drop in-flight ops.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_d;
         for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign t_out = tag_q[DEPTH-1];

   // Any valid tag means an op is still inside the multiplier.
   always_comb begin
      tag_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) tag_busy = tag_busy | tag_q[i].valid;
   end

   // Return stage: route aligned results, flag any tag/result mismatch.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         resp_valid_q <= '0;
         resp_c_q     <= '0;
         err_q        <= 1'b0;
      end else if (t_out.valid && mul_valid_in) begin
         resp_c_q     <= mul_c_in;
         resp_valid_q <= NUM_REQ'(1) << t_out.id;
      end else begin
         resp_valid_q <= '0;
         if (t_out.valid != mul_valid_in) err_q <= 1'b1;
      end
   end

   assign mul_valid_out  = mul_valid_q;
   assign mul_a_out      = mul_a_q;
   assign mul_b_out      = mul_b_q;
   assign resp_valid_out = resp_valid_q;
   assign resp_c_out     = resp_c_q;
   assign err_out        = err_q;
   assign busy_out       = mul_valid_q | tag_busy;

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Bench for fp32_mul_arbiter with a behavioural fp32 multiplier attached.
module tb_fp32_mul_arbiter;

   localparam int N = 4;
   localparam int L = 7;

   logic                clk_in       = 1'b0;
   logic                rst_in       = 1'b0;
   logic                hold_in      = 1'b0;
   logic [N-1:0]        req_valid_in = '0;
   logic [N-1:0][31:0]  req_a_in     = '0;
   logic [N-1:0][31:0]  req_b_in     = '0;
   logic [N-1:0]        req_ready_out;
   logic                mul_valid_out;
   logic [31:0]         mul_a_out;
   logic [31:0]         mul_b_out;
   logic                mul_valid_in;
   logic [31:0]         mul_c_in;
   logic [N-1:0]        resp_valid_out;
   logic [31:0]         resp_c_out;
   logic                busy_out;
   logic                err_out;

   fp32_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .hold_in        (hold_in),
      .req_valid_in   (req_valid_in),
      .req_a_in       (req_a_in),
      .req_b_in       (req_b_in),
      .req_ready_out  (req_ready_out),
      .mul_valid_out  (mul_valid_out),
      .mul_a_out      (mul_a_out),
      .mul_b_out      (mul_b_out),
      .mul_valid_in   (mul_valid_in),
      .mul_c_in       (mul_c_in),
      .resp_valid_out (resp_valid_out),
      .resp_c_out     (resp_c_out),
      .busy_out       (busy_out),
      .err_out        (err_out)
   );

   always #5 clk_in = ~clk_in;

   // Truncating fp32 multiply for normal operands.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] ma, mb, p;
      logic [22:0] m;
      int          e;
      ma = {24'd0, 1'b1, a[22:0]};
      mb = {24'd0, 1'b1, b[22:0]};
      p  = ma * mb;
      e  = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         e = e + 1;
         m = p[46:24];
      end else begin
         m = p[45:23];
      end
      return {a[31] ^ b[31], 8'(e), m};
   endfunction

   // Multiplier model: result appears L+1 edges after mul_valid_out rises.
   logic        mv [L+1];
   logic [31:0] mc [L+1];
   logic        inj = 1'b0;

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i <= L; i++) begin
            mv[i] <= 1'b0;
            mc[i] <= '0;
         end
      end else begin
         mv[0] <= mul_valid_out;
         mc[0] <= fmul(mul_a_out, mul_b_out);
         for (int i = 1; i <= L; i++) begin
            mv[i] <= mv[i-1];
            mc[i] <= mc[i-1];
         end
      end
   end

   assign mul_valid_in = mv[L] | inj;
   assign mul_c_in     = mc[L];

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      int          due;
      int          id;
      logic [31:0] c;
   } exp_t;

   exp_t eq[$];
   int   m_ptr  = N - 1;
   logic m_err  = 1'b0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual %h required %h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Round-robin decision from the arbitration rules.
   function automatic int model_grant();
      if (hold_in) return -1;
      for (int k = 1; k <= N; k++) begin
         if (req_valid_in[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   // One clock: check the combinational grant, advance, check registered outputs.
   task automatic tick(output int gi);
      exp_t e;
      #1;
      gi = model_grant();
      chk("ready", 32'(req_ready_out), (gi >= 0) ? (32'd1 << gi) : 32'd0);
      if (gi >= 0) begin
         e.due = cyc + L + 3;
         e.id  = gi;
         e.c   = fmul(req_a_in[gi], req_b_in[gi]);
         eq.push_back(e);
         m_ptr = gi;
      end
      if (inj) m_err = 1'b1;
      @(posedge clk_in);
      #1;
      chk("mul_valid", 32'(mul_valid_out), 32'(gi >= 0));
      if (gi >= 0) begin
         chk("mul_a", mul_a_out, req_a_in[gi]);
         chk("mul_b", mul_b_out, req_b_in[gi]);
      end
      if (eq.size() > 0 && eq[0].due == cyc) begin
         chk("resp_valid", 32'(resp_valid_out), 32'd1 << eq[0].id);
         chk("resp_c", resp_c_out, eq[0].c);
         void'(eq.pop_front());
      end else begin
         chk("resp_idle", 32'(resp_valid_out), 32'd0);
      end
      chk("busy", 32'(busy_out), 32'(eq.size() != 0));
      chk("err", 32'(err_out), 32'(m_err));
   endtask

   task automatic idle(input int n);
      int g;
      for (int i = 0; i < n; i++) tick(g);
   endtask

   function automatic logic [31:0] rnd_fp();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(112, 142)), 23'($urandom)};
   endfunction

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [4];
      int   g;
      int   exp_pair [4];

      vt[0] = '{id: 2, a: 32'h3FC0_0000, b: 32'h3FC0_0000, c: 32'h4010_0000};
      vt[1] = '{id: 0, a: 32'h3F80_0000, b: 32'h4000_0000, c: 32'h4000_0000};
      vt[2] = '{id: 1, a: 32'h4040_0000, b: 32'h4000_0000, c: 32'h40C0_0000};
      vt[3] = '{id: 3, a: 32'hC000_0000, b: 32'h3F00_0000, c: 32'hBF80_0000};
      exp_pair = '{1, 3, 1, 3};

      // Reset state, with requests pending.
      req_valid_in = '1;
      #2;
      chk("rst_ready", 32'(req_ready_out), 0);
      chk("rst_mul_valid", 32'(mul_valid_out), 0);
      chk("rst_resp_valid", 32'(resp_valid_out), 0);
      chk("rst_resp_c", resp_c_out, 0);
      chk("rst_busy", 32'(busy_out), 0);
      chk("rst_err", 32'(err_out), 0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;

      // All four continuously valid: a=1.0, b=i+1.
      for (int i = 0; i < N; i++) begin
         req_a_in[i] = 32'h3F80_0000;
         req_b_in[i] = 32'h3F80_0000 + (i == 0 ? 0 : 32'h0080_0000 + ((i - 1) << 22));
      end
      req_b_in[3] = 32'h4080_0000;
      for (int n = 0; n < 12; n++) begin
         tick(g);
         chk("rr_order", 32'(g), 32'(n % N));
      end
      req_valid_in = '0;
      idle(11);

      // Table of single ops, each checked 9 cycles after its transfer.
      for (int v = 0; v < 4; v++) begin
         req_valid_in[vt[v].id] = 1'b1;
         req_a_in[vt[v].id]     = vt[v].a;
         req_b_in[vt[v].id]     = vt[v].b;
         tick(g);
         chk("tbl_grant", 32'(g), 32'(vt[v].id));
         req_valid_in = '0;
         idle(9);
         chk("tbl_resp_valid", 32'(resp_valid_out), 32'd1 << vt[v].id);
         chk("tbl_resp_c", resp_c_out, vt[v].c);
         idle(1);
      end

      // Requesters 1 and 3 with pointer at 3.
      req_valid_in = 4'b1010;
      for (int n = 0; n < 4; n++) begin
         tick(g);
         chk("pair_grant", 32'(g), 32'(exp_pair[n]));
      end
      req_valid_in = '0;
      idle(11);

      // Hold with requests pending while two ops drain.
      req_valid_in = 4'b0001;
      tick(g);
      req_valid_in = 4'b0010;
      tick(g);
      req_valid_in = 4'b0100;
      hold_in      = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick(g);
         chk("hold_ready", 32'(req_ready_out), 0);
         chk("hold_mul_valid", 32'(mul_valid_out), 0);
      end
      for (int n = 0; n < 20 && busy_out; n++) tick(g);
      chk("hold_busy_drained", 32'(busy_out), 0);
      hold_in = 1'b0;
      tick(g);
      chk("hold_release_grant", 32'(g), 2);
      req_valid_in = '0;
      idle(11);

      // Reset in the middle of two in-flight ops.
      req_valid_in = 4'b0001;
      tick(g);
      req_valid_in = 4'b0010;
      tick(g);
      req_valid_in = '0;
      idle(2);
      req_valid_in = 4'b1000;
      #3;
      rst_in = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(req_ready_out), 0);
      chk("mid_rst_mul_valid", 32'(mul_valid_out), 0);
      chk("mid_rst_mul_a", mul_a_out, 0);
      chk("mid_rst_mul_b", mul_b_out, 0);
      chk("mid_rst_resp_valid", 32'(resp_valid_out), 0);
      chk("mid_rst_resp_c", resp_c_out, 0);
      chk("mid_rst_busy", 32'(busy_out), 0);
      chk("mid_rst_err", 32'(err_out), 0);
      eq.delete();
      m_ptr = N - 1;
      m_err = 1'b0;
      req_valid_in = '0;
      @(posedge clk_in);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      idle(12);

      // Stray multiplier result with nothing issued.
      inj = 1'b1;
      tick(g);
      inj = 1'b0;
      chk("stray_err", 32'(err_out), 1);
      idle(3);
      req_valid_in = 4'b0001;
      req_a_in[0]  = 32'h3FC0_0000;
      req_b_in[0]  = 32'h4000_0000;
      tick(g);
      req_valid_in = '0;
      idle(9);
      chk("after_err_resp_valid", 32'(resp_valid_out), 32'b0001);
      chk("after_err_resp_c", resp_c_out, 32'h4040_0000);
      chk("after_err_sticky", 32'(err_out), 1);

      // Random traffic against the scoreboard.
      for (int n = 0; n < 300; n++) begin
         hold_in = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid_in[i] && $urandom_range(0, 1) == 1) begin
               req_valid_in[i] = 1'b1;
               req_a_in[i]     = rnd_fp();
               req_b_in[i]     = rnd_fp();
            end
         end
         tick(g);
         if (g >= 0) req_valid_in[g] = 1'b0;
      end
      hold_in      = 1'b0;
      req_valid_in = '0;
      idle(12);
      chk("final_queue_empty", 32'(eq.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
